cc_receive: RTL and testbench

Serial receiver for the CC link: deserialises the framed byte stream produced by the CC transmitter and writes each byte into a subframe buffer RAM. It samples 1-start, 8-data (LSB first), 1-stop characters at a fixed clocks-per-bit rate. It fills SUBFRAME consecutive addresses, then pulses DONE for the downstream consumer.

---
 rtl/cc_pkg.sv | 19 +
 rtl/cc_rx_sync.sv | 24 ++
 rtl/cc_receive.sv | 136 +++++++++++++
 tb/tb_cc_receive.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// Shared constants for the CC link: subframe size, serial bit timing and the
// receiver state encoding. The transmitter uses the same SUBFRAME/BIT_CLKS
// values so both ends agree on framing and bit period.
package cc_pkg;

   localparam int SUBFRAME  = 2048;
   localparam int BIT_CLKS  = 51;
   localparam int HALF_CLKS = 25;

   typedef enum logic [2:0] {
      RX_IDLE    = 3'd0,
      RX_START   = 3'd1,
      RX_DATA    = 3'd2,
      RX_STOP    = 3'd3,
      RX_WRITE   = 3'd4,
      RX_RECOVER = 3'd5
   } rx_state_t;

endpackage

// File: rtl/cc_rx_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input.
// Latency: two clock cycles from d to q.
// No backpressure; both flops reset to 1 so an idle line never looks like a start edge.
module cc_rx_sync (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // Double-register the asynchronous input to settle metastability.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/cc_receive.sv
// CC link serial receiver: 8N1 characters into consecutive subframe RAM addresses.
// Latency: wren one cycle after the stop-bit sample; DONE one cycle after the last write.
// No backpressure: the RAM accepts every write strobe; bad stop bits drop the byte.
module cc_receive #(
   parameter int SUBFRAME  = cc_pkg::SUBFRAME,
   parameter int BIT_CLKS  = cc_pkg::BIT_CLKS,
   parameter int HALF_CLKS = cc_pkg::HALF_CLKS
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rx,
   output logic [11:0] wraddress,
   output logic [7:0]  wrdata,
   output logic        wren,
   output logic        DONE,
   output logic        frame_err,
   output logic        busy
);

   import cc_pkg::*;

   localparam logic [7:0]  HALF_TC = 8'(HALF_CLKS - 1);
   localparam logic [7:0]  BIT_TC  = 8'(BIT_CLKS - 1);
   localparam logic [12:0] LAST    = 13'(SUBFRAME - 1);

   rx_state_t   state;
   logic        rx_s;
   logic [7:0]  cnt;
   logic [3:0]  bit_cnt;
   logic [7:0]  shreg;
   logic [12:0] byte_cnt;

   cc_rx_sync u_sync (
      .clock (clock),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   // Receive FSM: mid-bit sampling, byte assembly, RAM write and subframe wrap.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= RX_IDLE;
         cnt       <= 8'd0;
         bit_cnt   <= 4'd0;
         shreg     <= 8'd0;
         byte_cnt  <= 13'd0;
         wraddress <= 12'd0;
         wrdata    <= 8'd0;
         wren      <= 1'b0;
         DONE      <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         // Strobes are single-cycle unless a state re-asserts them.
         wren      <= 1'b0;
         DONE      <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            RX_IDLE: begin
               if (!rx_s) begin
                  cnt   <= 8'd0;
                  state <= RX_START;
                  busy  <= 1'b1;
               end
            end
            RX_START: begin
               if (cnt == HALF_TC) begin
                  if (!rx_s) begin
                     cnt     <= 8'd0;
                     bit_cnt <= 4'd0;
                     state   <= RX_DATA;
                  end else begin
                     // Line went back high before mid start bit: a glitch.
                     state <= RX_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            RX_DATA: begin
               if (cnt == BIT_TC) begin
                  cnt     <= 8'd0;
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     state <= RX_STOP;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            RX_STOP: begin
               if (cnt == BIT_TC) begin
                  cnt <= 8'd0;
                  if (rx_s) begin
                     wren      <= 1'b1;
                     wrdata    <= shreg;
                     wraddress <= byte_cnt[11:0];
                     state     <= RX_WRITE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= RX_RECOVER;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            RX_WRITE: begin
               if (byte_cnt == LAST) begin
                  byte_cnt  <= 13'd0;
                  wraddress <= 12'd0;
                  DONE      <= 1'b1;
               end else begin
                  byte_cnt <= byte_cnt + 13'd1;
               end
               state <= RX_IDLE;
               busy  <= 1'b0;
            end
            RX_RECOVER: begin
               // Hold off until the line returns idle so a stuck-low line is not re-framed.
               if (rx_s) begin
                  state <= RX_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= RX_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cc_receive.sv
// Scoreboard bench for cc_receive: directed frames on a default-rate instance and a
// full 2048-byte subframe on a fast-bit instance; a monitor pops expected writes.
module tb_cc_receive;

   typedef struct {
      bit          ferr;
      logic [11:0] addr;
      logic [7:0]  data;
      bit          done;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_a, reset_b, rx_a, rx_b;
   logic [11:0] wraddress_a, wraddress_b;
   logic [7:0]  wrdata_a, wrdata_b;
   logic        wren_a, wren_b, done_a, done_b, ferr_a, ferr_b, busy_a, busy_b;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;
   int          exp_addr_a = 0;
   int          exp_addr_b = 0;
   int          done_cnt_a = 0, done_cnt_b = 0, ferr_cnt_a = 0, ferr_cnt_b = 0;
   bit          done_exp_a = 1'b0, done_exp_b = 1'b0;
   exp_t        q_a[$];
   exp_t        q_b[$];

   always #5 clock = ~clock;

   cc_receive u_dut (
      .clock     (clock),
      .reset     (reset_a),
      .rx        (rx_a),
      .wraddress (wraddress_a),
      .wrdata    (wrdata_a),
      .wren      (wren_a),
      .DONE      (done_a),
      .frame_err (ferr_a),
      .busy      (busy_a)
   );

   cc_receive #(.SUBFRAME(2048), .BIT_CLKS(3), .HALF_CLKS(1)) u_sub (
      .clock     (clock),
      .reset     (reset_b),
      .rx        (rx_b),
      .wraddress (wraddress_b),
      .wrdata    (wrdata_b),
      .wren      (wren_b),
      .DONE      (done_b),
      .frame_err (ferr_b),
      .busy      (busy_b)
   );

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: event missing or unexpected", name);
   endtask

   task automatic drive(input int sel, input logic v);
      if (sel == 0) rx_a = v;
      else rx_b = v;
   endtask

   // Push the expected RAM write (or frame error) for the next frame on a channel.
   task automatic push_exp(input int sel, input bit ferr, input logic [7:0] d);
      exp_t e;
      e.ferr = ferr;
      e.data = d;
      e.addr = 12'd0;
      e.done = 1'b0;
      if (sel == 0) begin
         if (!ferr) begin
            e.addr = 12'(exp_addr_a);
            e.done = (exp_addr_a == 2047);
            exp_addr_a = (exp_addr_a + 1) % 2048;
         end
         q_a.push_back(e);
      end else begin
         if (!ferr) begin
            e.addr = 12'(exp_addr_b);
            e.done = (exp_addr_b == 2047);
            exp_addr_b = (exp_addr_b + 1) % 2048;
         end
         q_b.push_back(e);
      end
   endtask

   // One 8N1 character; the line is left at the stop-bit level.
   task automatic send_frame(input int sel, input logic [7:0] d, input logic stop, input int per);
      drive(sel, 1'b0);
      repeat (per) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         drive(sel, d[i]);
         repeat (per) @(negedge clock);
      end
      drive(sel, stop);
      repeat (per) @(negedge clock);
   endtask

   task automatic send_byte(input int sel, input logic [7:0] d, input int per);
      push_exp(sel, 1'b0, d);
      send_frame(sel, d, 1'b1, per);
   endtask

   task automatic wait_drain(input int sel);
      int k = 0;
      while (((sel == 0) ? q_a.size() : q_b.size()) != 0 && k < 3000) begin
         @(negedge clock);
         k++;
      end
      if (((sel == 0) ? q_a.size() : q_b.size()) != 0) fail_now((sel == 0) ? "a_drain_timeout" : "b_drain_timeout");
   endtask

   // Monitor: compare every write / frame error against the scoreboard heads.
   always @(negedge clock) begin
      exp_t e;
      if (done_a || done_exp_a) check("a_done", done_a, done_exp_a);
      if (done_b || done_exp_b) check("b_done", done_b, done_exp_b);
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
      done_exp_a = 1'b0;
      done_exp_b = 1'b0;
      if (wren_a || ferr_a) begin
         if (ferr_a) ferr_cnt_a++;
         if (q_a.size() == 0) fail_now("a_unexpected_output");
         else begin
            e = q_a.pop_front();
            check("a_kind_ferr", ferr_a, e.ferr);
            if (!e.ferr) begin
               check("a_wraddress", wraddress_a, e.addr);
               check("a_wrdata", wrdata_a, e.data);
            end
            done_exp_a = e.done;
         end
      end
      if (wren_b || ferr_b) begin
         if (ferr_b) ferr_cnt_b++;
         if (q_b.size() == 0) fail_now("b_unexpected_output");
         else begin
            e = q_b.pop_front();
            check("b_kind_ferr", ferr_b, e.ferr);
            if (!e.ferr) begin
               check("b_wraddress", wraddress_b, e.addr);
               check("b_wrdata", wrdata_b, e.data);
            end
            done_exp_b = e.done;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_a = 1'b0;
      reset_b = 1'b0;
      rx_a    = 1'b1;
      rx_b    = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_wraddress", wraddress_a, 0);
      check("rst_wrdata", wrdata_a, 0);
      check("rst_wren", wren_a, 0);
      check("rst_done", done_a, 0);
      check("rst_frame_err", ferr_a, 0);
      check("rst_busy", busy_a, 0);
      reset_a = 1'b1;
      reset_b = 1'b1;
      repeat (5) @(negedge clock);

      fork
         begin : path_a
            logic [7:0] d77;
            // Single byte at the nominal rate.
            send_byte(0, 8'hA5, 51);
            wait_drain(0);
            repeat (60) @(negedge clock);
            // Short low glitch on idle line must not produce a write.
            rx_a = 1'b0;
            repeat (8) @(negedge clock);
            check("glitch_busy", busy_a, 1);
            repeat (2) @(negedge clock);
            rx_a = 1'b1;
            repeat (60) @(negedge clock);
            check("glitch_back_idle", busy_a, 0);
            // Bad stop bit, then line stuck low.
            push_exp(0, 1'b1, 8'h00);
            send_frame(0, 8'h3C, 1'b0, 51);
            repeat (200) @(negedge clock);
            check("recover_busy", busy_a, 1);
            check("recover_ferr_cnt", ferr_cnt_a, 1);
            rx_a = 1'b1;
            repeat (10) @(negedge clock);
            check("recover_exit", busy_a, 0);
            send_byte(0, 8'h11, 51);
            // Rate tolerance: slow and fast transmitters.
            for (int i = 0; i < 4; i++) begin
               send_byte(0, 8'($urandom_range(1, 255)), 49);
               repeat (5) @(negedge clock);
            end
            for (int i = 0; i < 4; i++) begin
               send_byte(0, 8'($urandom_range(1, 255)), 53);
               repeat (5) @(negedge clock);
            end
            wait_drain(0);
            repeat (20) @(negedge clock);
            // Reset during bit 4 of 0x77.
            d77 = 8'h77;
            rx_a = 1'b0;
            repeat (51) @(negedge clock);
            for (int i = 0; i < 4; i++) begin
               rx_a = d77[i];
               repeat (51) @(negedge clock);
            end
            rx_a = d77[4];
            repeat (25) @(negedge clock);
            check("pre_reset_busy", busy_a, 1);
            reset_a = 1'b0;
            #1;
            check("midrst_wraddress", wraddress_a, 0);
            check("midrst_wrdata", wrdata_a, 0);
            check("midrst_wren", wren_a, 0);
            check("midrst_busy", busy_a, 0);
            exp_addr_a = 0;
            rx_a = 1'b1;
            repeat (10) @(negedge clock);
            reset_a = 1'b1;
            repeat (10) @(negedge clock);
            send_byte(0, 8'h42, 51);
         end
         begin : path_b
            // Full subframe with data = address, then one wrapped byte.
            for (int i = 0; i < 2048; i++) begin
               send_byte(1, 8'(i), 3);
               repeat (2) @(negedge clock);
            end
            send_byte(1, 8'h5A, 3);
         end
      join

      wait_drain(0);
      wait_drain(1);
      repeat (10) @(negedge clock);
      check("a_pending", q_a.size(), 0);
      check("b_pending", q_b.size(), 0);
      check("a_done_count", done_cnt_a, 0);
      check("b_done_count", done_cnt_b, 1);
      check("a_ferr_total", ferr_cnt_a, 1);
      check("b_ferr_total", ferr_cnt_b, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
